// File: rtl/viterbi_chan_pkg.sv
// Shared types and constants for the Viterbi channel error model.
package viterbi_chan_pkg;

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        RANDOM   = 2'd1,
        BURST    = 2'd2,
        PERIODIC = 2'd3
    } chan_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    localparam logic [31:0] LFSR_POLY    = 32'h80200003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE10001;

    // Right-shifting Galois form: taps x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR that steps only when adv_i is high.
module lfsr32
    import viterbi_chan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_o <= seed_i;
        end else if (adv_i) begin
            state_o <= lfsr_next(state_o);
        end
    end

endmodule

// File: rtl/viterbi_chan_model.sv
// Channel error injector: corrupts encoder symbols in PASS/RANDOM/BURST/PERIODIC
// modes with one cycle of latency and keeps saturating error statistics.
module viterbi_chan_model
    import viterbi_chan_pkg::*;
#(
    parameter int unsigned W         = 2,
    parameter int unsigned N         = 4,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [31:0] SEED      = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode_i,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic [W-1:0] sym_i,
    output logic         valid_o,
    output logic [W-1:0] sym_o,
    output logic [W-1:0] err_mask_o,
    output logic [31:0]  sym_ct_o,
    output logic [31:0]  err_sym_ct_o,
    output logic [31:0]  err_bit_ct_o
);

    localparam logic [31:0]  HIT_MASK = 32'((64'd1 << N) - 64'd1);
    localparam logic [W-1:0] MASK_ONE = W'(1);
    localparam logic [N-1:0] PER_ONE  = N'(1);
    localparam logic [7:0]   BURST_LD = 8'(BURST_LEN - 1);

    logic [31:0]  lfsr;
    chan_mode_e   mode_in;
    chan_mode_e   mode_q;
    logic         mode_chg;
    burst_state_e state;
    logic [7:0]   burst_ct;
    logic [N-1:0] period_ct;
    logic         hit;
    logic [W-1:0] rnd_field;
    logic [W-1:0] mask;
    logic [3:0]   pop;
    logic [31:0]  sym_ct;
    logic [31:0]  err_sym_ct;
    logic [31:0]  err_bit_ct;

    lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (valid_i),
        .seed_i  (SEED),
        .state_o (lfsr)
    );

    assign mode_in   = chan_mode_e'(mode_i);
    assign mode_chg  = (mode_in != mode_q);
    assign hit       = ((lfsr & HIT_MASK) == '0);
    assign rnd_field = W'(lfsr >> 16);

    always_comb begin
        mask = '0;
        if (valid_i) begin
            unique case (mode_q)
                PASS:     mask = '0;
                RANDOM:   if (hit) mask = (rnd_field == '0) ? MASK_ONE : rnd_field;
                BURST:    if (state == ST_BURST || hit) mask = '1;
                PERIODIC: if (period_ct == '0) mask = MASK_ONE;
                default:  mask = '0;
            endcase
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pop = pop + 4'(mask[i]);
        end
    end

    // Mode register tracks mode_i; any change aborts the burst and restarts the period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q    <= mode_in;
            state     <= ST_IDLE;
            burst_ct  <= '0;
            period_ct <= '0;
        end else begin
            if (valid_i && mode_q == BURST) begin
                unique case (state)
                    ST_IDLE: begin
                        if (hit && BURST_LEN > 1) begin
                            state    <= ST_BURST;
                            burst_ct <= BURST_LD;
                        end
                    end
                    ST_BURST: begin
                        burst_ct <= burst_ct - 8'd1;
                        if (burst_ct <= 8'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
            if (valid_i && mode_q == PERIODIC) begin
                period_ct <= period_ct + PER_ONE;
            end
            if (mode_chg) begin
                mode_q    <= mode_in;
                state     <= ST_IDLE;
                burst_ct  <= '0;
                period_ct <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o    <= 1'b0;
            sym_o      <= '0;
            err_mask_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sym_o      <= sym_i ^ mask;
                err_mask_o <= mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            sym_ct     <= '0;
            err_sym_ct <= '0;
            err_bit_ct <= '0;
        end else if (valid_i) begin
            sym_ct     <= sat_add(sym_ct, 32'd1);
            if (mask != '0) begin
                err_sym_ct <= sat_add(err_sym_ct, 32'd1);
            end
            err_bit_ct <= sat_add(err_bit_ct, 32'(pop));
        end
    end

    assign sym_ct_o     = sym_ct;
    assign err_sym_ct_o = err_sym_ct;
    assign err_bit_ct_o = err_bit_ct;

endmodule

// File: tb/tb_viterbi_chan_model.sv
// Self-checking bench: behavioural channel model compared every cycle plus directed checks.
module tb_viterbi_chan_model;

    localparam int unsigned W    = 2;
    localparam int unsigned N    = 4;
    localparam int unsigned BL   = 4;
    localparam logic [31:0] SEED = 32'hACE10001;

    logic         clk;
    logic         rst;
    logic [1:0]   mode_i;
    logic         clear_i;
    logic         valid_i;
    logic [W-1:0] sym_i;
    logic         valid_o;
    logic [W-1:0] sym_o;
    logic [W-1:0] err_mask_o;
    logic [31:0]  sym_ct_o;
    logic [31:0]  err_sym_ct_o;
    logic [31:0]  err_bit_ct_o;

    int n_cmp;
    int n_err;

    // model state
    logic         m_ready;
    logic         m_valid;
    logic [W-1:0] m_sym;
    logic [W-1:0] m_mask;
    logic [W-1:0] mk;
    longint       m_sym_ct, m_err_sym_ct, m_err_bit_ct;
    logic [31:0]  m_lfsr;
    logic [1:0]   m_mode;
    int           burst_left;
    int           period_idx;
    logic         hit;

    logic [W-1:0] ref_pat [0:199];

    viterbi_chan_model #(
        .W         (W),
        .N         (N),
        .BURST_LEN (BL),
        .SEED      (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_i       (mode_i),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .sym_i        (sym_i),
        .valid_o      (valid_o),
        .sym_o        (sym_o),
        .err_mask_o   (err_mask_o),
        .sym_ct_o     (sym_ct_o),
        .err_sym_ct_o (err_sym_ct_o),
        .err_bit_ct_o (err_bit_ct_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > 64'hFFFFFFFF) ? 64'hFFFFFFFF : v;
    endfunction

    // Behavioural channel model, evaluated on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1'b0; m_sym = '0; m_mask = '0;
            m_sym_ct = 0; m_err_sym_ct = 0; m_err_bit_ct = 0;
            m_lfsr = SEED; burst_left = 0; period_idx = 0;
            m_mode = mode_i; m_ready = 1'b1;
        end else begin
            mk = '0;
            if (valid_i) begin
                hit = ((m_lfsr % (32'd1 << N)) == 0);
                case (m_mode)
                    2'd1: if (hit) begin
                        mk = W'((m_lfsr >> 16) % (32'd1 << W));
                        if (mk == 0) mk = 1;
                    end
                    2'd2: if (burst_left > 0) begin
                        mk = '1; burst_left = burst_left - 1;
                    end else if (hit) begin
                        mk = '1; burst_left = BL - 1;
                    end
                    2'd3: begin
                        if (period_idx == 0) mk = 1;
                        period_idx = (period_idx + 1) % (1 << N);
                    end
                    default: mk = '0;
                endcase
                if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr >> 1) ^ 32'h80200003;
                else                 m_lfsr = m_lfsr >> 1;
                m_sym  = sym_i ^ mk;
                m_mask = mk;
            end
            m_valid = valid_i;
            if (clear_i) begin
                m_sym_ct = 0; m_err_sym_ct = 0; m_err_bit_ct = 0;
            end else if (valid_i) begin
                m_sym_ct     = sat(m_sym_ct + 1);
                m_err_sym_ct = sat(m_err_sym_ct + ((mk != 0) ? 1 : 0));
                m_err_bit_ct = sat(m_err_bit_ct + $countones(mk));
            end
            if (mode_i != m_mode) begin
                burst_left = 0; period_idx = 0; m_mode = mode_i;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("valid_o",      32'(valid_o),    32'(m_valid));
            check("sym_o",        32'(sym_o),      32'(m_sym));
            check("err_mask_o",   32'(err_mask_o), 32'(m_mask));
            check("sym_ct_o",     sym_ct_o,        32'(m_sym_ct));
            check("err_sym_ct_o", err_sym_ct_o,    32'(m_err_sym_ct));
            check("err_bit_ct_o", err_bit_ct_o,    32'(m_err_bit_ct));
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] s, input logic [1:0] m, input logic c);
        valid_i = v; sym_i = s; mode_i = m; clear_i = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_o"},    32'(valid_o),    32'd0);
        check({tag, "_sym_o"},      32'(sym_o),      32'd0);
        check({tag, "_err_mask_o"}, 32'(err_mask_o), 32'd0);
        check({tag, "_sym_ct"},     sym_ct_o,        32'd0);
        check({tag, "_err_sym_ct"}, err_sym_ct_o,    32'd0);
        check({tag, "_err_bit_ct"}, err_bit_ct_o,    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] s, last_s;
        logic         v;
        int           run, bursts, found, ref_bursts;
        n_cmp = 0; n_err = 0; m_ready = 1'b0;
        rst = 1'b0; mode_i = 2'd0; clear_i = 1'b0; valid_i = 1'b0; sym_i = '0;
        @(posedge clk); #1;
        cyc(1'b1, 2'b11, 2'd0, 1'b0);
        check_all_zero("reset");
        rst = 1'b1;

        // PASS: first step pins the model LFSR, then 1000 symbols total
        last_s = 2'b10;
        cyc(1'b1, last_s, 2'd0, 1'b0);
        check("model_lfsr_step1", m_lfsr, 32'hD6508003);
        for (int i = 1; i < 1000; i++) begin
            last_s = W'($urandom_range(0, 3));
            cyc(1'b1, last_s, 2'd0, 1'b0);
        end
        check("pass_sym_delay", 32'(sym_o), 32'(last_s));
        check("pass_sym_ct", sym_ct_o, 32'd1000);
        check("pass_err_sym_ct", err_sym_ct_o, 32'd0);

        // PERIODIC: masks on symbols 0,16,...,144
        cyc(1'b0, '0, 2'd3, 1'b1);
        cyc(1'b1, 2'b00, 2'd3, 1'b0);
        check("per_first_mask", 32'(err_mask_o), 32'd1);
        cyc(1'b1, 2'b00, 2'd3, 1'b0);
        check("per_second_mask", 32'(err_mask_o), 32'd0);
        for (int i = 2; i < 160; i++) cyc(1'b1, W'($urandom_range(0, 3)), 2'd3, 1'b0);
        check("per_sym_ct", sym_ct_o, 32'd160);
        check("per_err_sym_ct", err_sym_ct_o, 32'd10);
        check("per_err_bit_ct", err_bit_ct_o, 32'd10);

        // RANDOM: 65536 symbols, exact match held by the per-cycle compare
        cyc(1'b0, '0, 2'd1, 1'b1);
        for (int i = 0; i < 65536; i++) cyc(1'b1, W'($urandom_range(0, 3)), 2'd1, 1'b0);
        check("rand_sym_ct", sym_ct_o, 32'd65536);
        check("rand_err_in_range", 32'(err_sym_ct_o >= 32'd3687 && err_sym_ct_o <= 32'd4505), 32'd1);

        // clear together with a valid symbol
        cyc(1'b1, 2'b01, 2'd1, 1'b1);
        check("clr_sym_ct", sym_ct_o, 32'd0);
        check("clr_err_sym_ct", err_sym_ct_o, 32'd0);
        check("clr_err_bit_ct", err_bit_ct_o, 32'd0);

        // BURST with gaps: every run of all-ones masks is a multiple of BL
        cyc(1'b0, '0, 2'd2, 1'b1);
        run = 0; bursts = 0;
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            cyc(v, W'($urandom_range(0, 3)), 2'd2, 1'b0);
            if (valid_o) begin
                if (err_mask_o == 2'b11) run++;
                else if (run > 0) begin
                    check("burst_run_len_mod", 32'(run % BL), 32'd0);
                    bursts++;
                    run = 0;
                end
            end
        end
        check("burst_seen", 32'(bursts >= 3), 32'd1);

        // abort mid-burst by switching to PASS
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            cyc(1'b1, '0, 2'd2, 1'b0);
            if (burst_left == 2) found = 1;
        end
        check("midburst_found", 32'(found), 32'd1);
        cyc(1'b0, '0, 2'd0, 1'b0);
        cyc(1'b1, 2'b10, 2'd0, 1'b0);
        check("abort_mask", 32'(err_mask_o), 32'd0);
        check("abort_sym", 32'(sym_o), 32'd2);

        // reference BURST pattern from SEED
        rst = 1'b0;
        cyc(1'b0, '0, 2'd2, 1'b0);
        rst = 1'b1;
        ref_bursts = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, 2'b00, 2'd2, 1'b0);
            ref_pat[i] = m_mask;
            if (m_mask != 0) ref_bursts++;
        end
        check("ref_has_burst", 32'(ref_bursts > 0), 32'd1);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            cyc(1'b1, '0, 2'd2, 1'b0);
            if (burst_left == 2) found = 1;
        end
        check("midburst2_found", 32'(found), 32'd1);
        rst = 1'b0;
        cyc(1'b1, 2'b11, 2'd2, 1'b0);
        check_all_zero("midrst");
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, 2'b00, 2'd2, 1'b0);
            check("repeat_pattern", 32'(err_mask_o), 32'(ref_pat[i]));
        end

        // saturation from preloaded counters
        cyc(1'b0, '0, 2'd3, 1'b0);
        force dut.sym_ct     = 32'hFFFFFFFE;
        force dut.err_sym_ct = 32'hFFFFFFFE;
        force dut.err_bit_ct = 32'hFFFFFFFE;
        m_sym_ct = 64'hFFFFFFFE; m_err_sym_ct = 64'hFFFFFFFE; m_err_bit_ct = 64'hFFFFFFFE;
        #1;
        release dut.sym_ct;
        release dut.err_sym_ct;
        release dut.err_bit_ct;
        cyc(1'b1, 2'b00, 2'd3, 1'b0);
        check("sat1_sym_ct", sym_ct_o, 32'hFFFFFFFF);
        check("sat1_err_sym_ct", err_sym_ct_o, 32'hFFFFFFFF);
        check("sat1_err_bit_ct", err_bit_ct_o, 32'hFFFFFFFF);
        for (int i = 1; i < 20; i++) cyc(1'b1, 2'b00, 2'd3, 1'b0);
        check("sat2_sym_ct", sym_ct_o, 32'hFFFFFFFF);
        check("sat2_err_sym_ct", err_sym_ct_o, 32'hFFFFFFFF);
        check("sat2_err_bit_ct", err_bit_ct_o, 32'hFFFFFFFF);

        cyc(1'b0, '0, 2'd3, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
